// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types and constants
package fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response and decode handshake bundle
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );
endinterface

// File: rtl/fetch_unit_queue.sv
// fetch_queue: in-order circular buffer of fetch entries, allocated at issue and filled by responses
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         alloc_i,
  input  logic [31:0]  alloc_pc_i,
  input  logic         fill_i,
  input  logic [31:0]  fill_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic [CW-1:0] unfilled_o,
  output fetch_entry_t head_o,
  output logic         head_valid_o
);
  fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, fill_q;
  logic [CW-1:0] count_q, unfilled_q;
  always_ff @(posedge clk or posedge reset)
    if (reset || flush_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      head_q     <= head_q + PW'(pop_i);
      tail_q     <= tail_q + PW'(alloc_i);
      fill_q     <= fill_q + PW'(fill_i);
      count_q    <= count_q + CW'(alloc_i) - CW'(pop_i);
      unfilled_q <= unfilled_q + CW'(alloc_i) - CW'(fill_i);
    end
  // alloc never targets the fill slot: the tail slot is free, the fill slot is occupied
  always_ff @(posedge clk) begin
    if (alloc_i && !flush_i) mem_q[tail_q] <= '{pc: alloc_pc_i, instr: NOP_INSTR, filled: 1'b0};
    if (fill_i && !flush_i) begin
      mem_q[fill_q].instr  <= fill_data_i;
      mem_q[fill_q].filled <= 1'b1;
    end
  end
  assign full_o       = count_q == CW'(DEPTH);
  assign unfilled_o   = unfilled_q;
  assign head_o       = mem_q[head_q];
  assign head_valid_o = count_q != '0 && head_o.filled;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem issue, redirect handling and wrong-path response dropping
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int QUEUE_DEPTH = 2,
  localparam int CW = $clog2(QUEUE_DEPTH + 1),
  localparam int DW = $clog2(2 * QUEUE_DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_branched,
  input  logic [31:0] branch_target,
  fetch_unit_if.master bus
);
  logic [31:0]   pc_q, pc_d;
  logic [DW-1:0] drop_q, drop_d;
  logic          full, fire, fill, pop, head_valid;
  logic [CW-1:0] unfilled;
  fetch_entry_t  head;
  assign bus.imem_req_valid = !full && !reset;
  assign bus.imem_req_addr  = pc_q;
  assign fire = bus.imem_req_valid && bus.imem_req_ready;
  assign fill = bus.imem_resp_valid && drop_q == '0 && !is_branched;
  assign pop  = head_valid && bus.if_ready;
  // on redirect every unfilled entry plus this cycle's accepted request becomes stale,
  // minus a response consumed on this very edge
  always_comb begin
    pc_d   = is_branched ? {branch_target[31:2], 2'b00} : fire ? pc_q + 32'd4 : pc_q;
    drop_d = is_branched ? DW'(int'(drop_q) + int'(unfilled) + int'(fire) - int'(bus.imem_resp_valid))
                         : drop_q - DW'(bus.imem_resp_valid && drop_q != '0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .alloc_i     (fire && !is_branched),
    .alloc_pc_i  (pc_q),
    .fill_i      (fill),
    .fill_data_i (bus.imem_resp_data),
    .pop_i       (pop),
    .flush_i     (is_branched),
    .full_o      (full),
    .unfilled_o  (unfilled),
    .head_o      (head),
    .head_valid_o(head_valid)
  );
  assign bus.if_valid    = head_valid;
  assign bus.if_instr    = head_valid ? head.instr : '0;
  assign bus.if_pc       = head_valid ? head.pc : '0;
  assign bus.if_pc_plus4 = head_valid ? head.pc + 32'd4 : '0;
  assert property (@(posedge clk) disable iff (reset)
    bus.imem_resp_valid && drop_q == '0 |-> unfilled != '0);
endmodule
